// File: rtl/ciphertext_packer.sv
// Collects per-row encrypt results into an LWE ciphertext (a[0..n-1], b), folds m*DELTA into b,
// reduces every word mod q and streams the words out in index order.
module ciphertext_packer #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 32,
  parameter int DIMENSION          = 3,
  parameter int DIM_WIDTH          = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [PLAINTEXT_WIDTH-1:0]  plaintext,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DIM_WIDTH:0]          in_row,
  input  logic [CIPHERTEXT_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CIPHERTEXT_WIDTH-1:0] out_data,
  output logic [DIM_WIDTH:0]          out_index,
  output logic                        out_last,
  output logic                        done,
  output logic                        err
);

  localparam int QW     = $clog2(CIPHERTEXT_MODULUS);
  localparam int IDX_W  = DIM_WIDTH + 1;
  localparam int NWORDS = DIMENSION + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIMENSION);
  localparam logic [CIPHERTEXT_WIDTH:0] DELTA_W =
    (CIPHERTEXT_WIDTH+1)'(CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t                     state, next_state;
  logic [PLAINTEXT_WIDTH-1:0] m_reg;
  logic [NWORDS-1:0]          mask;
  logic [QW-1:0]              word_buf [NWORDS];
  logic [IDX_W-1:0]           out_idx;
  logic                       err_reg;
  logic                       done_reg;

  logic                       start_fire;
  logic                       in_fire;
  logic                       row_ok;
  logic                       out_fire;
  logic                       last_fire;
  logic [NWORDS-1:0]          row_bit;
  logic [NWORDS-1:0]          mask_after;
  logic [CIPHERTEXT_WIDTH:0]  b_sum;
  logic [QW-1:0]              wr_word;
  logic                       unused_bits;

  // Row decode and word reduction; out-of-range rows decode to an empty row_bit.
  always_comb begin
    start_fire = (state == IDLE) && start;
    in_fire    = (state == COLLECT) && in_valid;
    row_ok     = (in_row <= LAST_IDX);
    row_bit    = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (in_row == IDX_W'(i)) row_bit[i] = 1'b1;
    end
    mask_after = mask | row_bit;
    b_sum      = {1'b0, in_data} + ((CIPHERTEXT_WIDTH+1)'(m_reg) * DELTA_W);
    wr_word    = (in_row == LAST_IDX) ? b_sum[QW-1:0] : in_data[QW-1:0];
    out_fire   = (state == DRAIN) && out_ready;
    last_fire  = out_fire && (out_idx == LAST_IDX);
  end

  assign unused_bits = ^b_sum[CIPHERTEXT_WIDTH:QW];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = COLLECT;
      COLLECT: if (in_fire && row_ok && (mask_after == '1)) next_state = DRAIN;
      DRAIN:   if (last_fire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg    <= '0;
      mask     <= '0;
      out_idx  <= '0;
      err_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= last_fire;
      if (start_fire) begin
        m_reg   <= plaintext;
        mask    <= '0;
        err_reg <= 1'b0;
      end
      if (in_fire) begin
        if (row_ok) mask    <= mask_after;
        else        err_reg <= 1'b1;
      end
      if (out_fire) out_idx <= last_fire ? '0 : out_idx + 1'b1;
    end
  end

  // Buffer contents are only meaningful once their mask bit is set, so no reset is needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NWORDS; i++) begin
      if (in_fire && row_bit[i]) word_buf[i] <= wr_word;
    end
  end

  always_comb begin
    out_data = '0;
    if (state == DRAIN) begin
      for (int i = 0; i < NWORDS; i++) begin
        if (out_idx == IDX_W'(i)) out_data = CIPHERTEXT_WIDTH'(word_buf[i]);
      end
    end
  end

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == DRAIN);
  assign out_index = out_idx;
  assign out_last  = (state == DRAIN) && (out_idx == LAST_IDX);
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_ciphertext_packer.sv
// Randomized bench for ciphertext_packer: rows are fed in arbitrary order with duplicates and
// bad indices, and the drained words are compared against a plain-arithmetic LWE packing model.
module tb_ciphertext_packer;

  localparam int PW    = 6;
  localparam int CW    = 32;
  localparam int DIM   = 3;
  localparam int DW    = 2;
  localparam int P     = 64;
  localparam int Q     = 1024;
  localparam int DELTA = Q / P;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [PW-1:0] plaintext;
  logic          in_valid;
  logic          in_ready;
  logic [DW:0]   in_row;
  logic [CW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_data;
  logic [DW:0]   out_index;
  logic          out_last;
  logic          done;
  logic          err;

  ciphertext_packer #(
    .PLAINTEXT_MODULUS(P), .PLAINTEXT_WIDTH(PW), .CIPHERTEXT_MODULUS(Q),
    .CIPHERTEXT_WIDTH(CW), .DIMENSION(DIM), .DIM_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .plaintext(plaintext),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            tx_row[$];
  logic [CW-1:0] tx_data[$];
  longint        exp_word[DIM+1];
  logic          mdl_err;
  int            mdl_m;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Outputs only change on posedge, so checking then driving at negedge is race-free.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic add_tx(input int r, input logic [CW-1:0] d);
    tx_row.push_back(r);
    tx_data.push_back(d);
  endtask

  function automatic logic [CW-1:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF - $urandom_range(0, 1100);
      1:       return $urandom_range(0, 1023);
      default: return $urandom;
    endcase
  endfunction

  task automatic build_random();
    int ord[DIM+1];
    int j, t;
    tx_row.delete();
    tx_data.delete();
    for (int i = 0; i <= DIM; i++) ord[i] = i;
    for (int i = DIM; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    for (int i = 0; i <= DIM; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if (i > 0 && $urandom_range(0, 1) == 1) add_tx(ord[$urandom_range(0, i-1)], rand_word());
        else                                   add_tx(int'($urandom_range(DIM+1, 7)), rand_word());
      end
      add_tx(ord[i], rand_word());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    checkOutput("rst_in_ready",  in_ready,  0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data",  out_data,  0);
    checkOutput("rst_out_index", out_index, 0);
    checkOutput("rst_out_last",  out_last,  0);
    checkOutput("rst_done",      done,      0);
    checkOutput("rst_err",       err,       0);
    rst = 1'b0;
  endtask

  task automatic idle_check();
    start = 1'b0; in_valid = 1'b1; in_row = 3'($urandom); in_data = $urandom;
    step();
    in_valid = 1'b0;
    checkOutput("done_once",      done,      0);
    checkOutput("idle_out_valid", out_valid, 0);
    checkOutput("idle_in_ready",  in_ready,  0);
  endtask

  // Packs one ciphertext from tx_row/tx_data; entered and left at a negedge in IDLE
  // (leaving on the done cycle, so an immediate next call is a back-to-back start).
  task automatic applyStimulus(input int m, input int stall_mode, input bit noise);
    int k, cycles, stalls;
    bit toggle;
    checkOutput("pre_start_in_ready",  in_ready,  0);
    checkOutput("pre_start_out_valid", out_valid, 0);
    start = 1'b1; plaintext = PW'(m); in_valid = 1'b0;
    step();
    mdl_m = m; mdl_err = 1'b0;
    start = 1'b0;
    checkOutput("collect_in_ready", in_ready,  1);
    checkOutput("start_clears_err", err,       0);
    checkOutput("collect_no_valid", out_valid, 0);
    foreach (tx_row[i]) begin
      if (noise && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; start = 1'b1; plaintext = PW'($urandom);
        step();
        checkOutput("gap_in_ready", in_ready, 1);
      end
      start     = noise ? 1'($urandom) : 1'b0;
      plaintext = noise ? PW'($urandom) : PW'(m);
      in_valid  = 1'b1; in_row = 3'(tx_row[i]); in_data = tx_data[i];
      step();
      if (tx_row[i] == DIM)
        exp_word[DIM] = (longint'(tx_data[i]) + longint'(mdl_m) * DELTA) % Q;
      else if (tx_row[i] < DIM)
        exp_word[tx_row[i]] = longint'(tx_data[i]) % Q;
      else
        mdl_err = 1'b1;
      in_valid = 1'b0; start = 1'b0;
      if (i < tx_row.size() - 1) begin
        checkOutput("row_in_ready", in_ready, 1);
        checkOutput("collect_err",  err,      mdl_err);
      end
    end
    checkOutput("latency_out_valid", out_valid, 1);
    checkOutput("drain_in_ready",    in_ready,  0);
    k = 0; cycles = 0; stalls = 0; toggle = 1'b1;
    while (k <= DIM && cycles < 200) begin
      checkOutput($sformatf("out_valid[%0d]", k), out_valid, 1);
      checkOutput("out_index", out_index, k);
      checkOutput($sformatf("out_data[%0d]", k), out_data, exp_word[k]);
      checkOutput("out_last",  out_last,  k == DIM);
      checkOutput("done_low",  done,      0);
      checkOutput("drain_err", err,       mdl_err);
      case (stall_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom);
        default: begin
          if (k == 1 && stalls < 3) begin
            out_ready = 1'b0;
            stalls++;
          end else if (k >= 1) begin
            out_ready = toggle;
            toggle = ~toggle;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      if (noise) begin
        start = 1'($urandom); plaintext = PW'($urandom);
        in_valid = 1'($urandom); in_row = 3'($urandom); in_data = $urandom;
      end
      step();
      if (out_ready) k++;
      cycles++;
    end
    out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
    if (k <= DIM) checkOutput("drain_timeout", k, DIM + 1);
    checkOutput("done_pulse",     done,      1);
    checkOutput("done_out_valid", out_valid, 0);
    checkOutput("done_in_ready",  in_ready,  0);
    checkOutput("done_out_last",  out_last,  0);
    checkOutput("done_err",       err,       mdl_err);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst = 1'b1; start = 1'b0; plaintext = '0; in_valid = 1'b0;
    in_row = '0; in_data = '0; out_ready = 1'b0;
    step();
    do_reset();

    // Rows in order, one row needing reduction
    tx_row.delete(); tx_data.delete();
    add_tx(0, 55); add_tx(1, 22); add_tx(2, 1030); add_tx(3, 100);
    applyStimulus(5, 0, 1'b0);
    idle_check();

    // Out-of-order rows, b wraps mod q
    tx_row.delete(); tx_data.delete();
    add_tx(3, 1000); add_tx(1, 10); add_tx(0, 20); add_tx(2, 30);
    applyStimulus(3, 0, 1'b0);
    idle_check();

    // Duplicate overwrite and out-of-range row
    tx_row.delete(); tx_data.delete();
    add_tx(0, 1); add_tx(1, 7); add_tx(1, 9); add_tx(5, 77); add_tx(2, 2); add_tx(3, 3);
    applyStimulus(9, 0, 1'b0);

    // Back-to-back start on the done cycle, with backpressure at index 1
    tx_row.delete(); tx_data.delete();
    add_tx(0, 32'hFFFF_FFFF); add_tx(1, 2047); add_tx(2, 512); add_tx(3, 32'hFFFF_FFF0);
    applyStimulus(12, 2, 1'b0);
    idle_check();

    // Reset in the middle of COLLECT
    start = 1'b1; plaintext = 6'd40;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_row = 3'd6; in_data = 32'd5;
    step();
    in_row = 3'd0; in_data = 32'd111;
    step();
    in_row = 3'd1; in_data = 32'd222;
    step();
    in_valid = 1'b0;
    checkOutput("pre_reset_err", err, 1);
    do_reset();
    tx_row.delete(); tx_data.delete();
    add_tx(2, 300); add_tx(0, 400); add_tx(3, 500); add_tx(1, 600);
    applyStimulus(63, 1, 1'b0);
    idle_check();

    // Randomized ciphertexts with noise on ignored inputs
    for (int n = 0; n < 25; n++) begin
      build_random();
      applyStimulus(int'($urandom_range(0, P-1)), int'($urandom_range(0, 2)), 1'b1);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
